// File: rtl/idli_sqi_mem.sv
`default_nettype none
// ============================================================================
// Module      : idli_sqi_mem
// Description : Single-lane SQI serial SRAM responder. Decodes 4-bit-wide
//               READ (0x03) and WRITE (0x02) transactions from the core's SQI
//               initiator and serves them from an internal byte array.
// Revision    : 1.0 - initial release
// ============================================================================
module idli_sqi_mem #(
  parameter int ADDR_W = 17
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sqi_cs,
  input  logic [3:0] i_sqi_sio,
  output logic [3:0] o_sqi_sio,
  output logic       o_sqi_sio_en
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INSTR  = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_READ   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

  localparam logic [7:0]        c_INSTR_READ  = 8'h03;
  localparam logic [7:0]        c_INSTR_WRITE = 8'h02;
  localparam logic [2:0]        c_ADDR_LAST   = 3'd5;  // six address nibbles
  localparam logic [2:0]        c_DUMMY_LAST  = 3'd1;  // two dummy nibbles
  localparam logic [ADDR_W-1:0] c_ADDR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Backing store; deliberately not reset so contents survive i_rst.
  logic [7:0] r_mem [2**ADDR_W];

  state_t            r_state,    w_state;
  logic [2:0]        r_cnt,      w_cnt;
  logic [3:0]        r_instr_hi, w_instr_hi;
  logic              r_is_read,  w_is_read;
  logic [ADDR_W-1:0] r_addr,     w_addr;
  logic              r_half,     w_half;      // 1: next nibble is the low half
  logic [3:0]        r_wdata_hi, w_wdata_hi;
  logic [3:0]        r_sio,      w_sio;
  logic              r_sio_en,   w_sio_en;
  logic              w_mem_we;
  logic [7:0]        w_mem_wdata;
  logic [7:0]        w_rd_byte;

  assign w_rd_byte    = r_mem[r_addr];
  assign o_sqi_sio    = r_sio;
  assign o_sqi_sio_en = r_sio_en;

  // Next-state and datapath decode; CS high overrides everything and deselects.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_instr_hi  = r_instr_hi;
    w_is_read   = r_is_read;
    w_addr      = r_addr;
    w_half      = r_half;
    w_wdata_hi  = r_wdata_hi;
    w_sio       = r_sio;
    w_sio_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_wdata = {r_wdata_hi, i_sqi_sio};

    if (i_sqi_cs) begin
      w_state = ST_IDLE;
      w_cnt   = 3'd0;
      w_half  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_instr_hi = i_sqi_sio;
          w_state    = ST_INSTR;
        end
        ST_INSTR: begin
          w_addr = '0;
          w_cnt  = 3'd0;
          case ({r_instr_hi, i_sqi_sio})
            c_INSTR_READ: begin
              w_is_read = 1'b1;
              w_state   = ST_ADDR;
            end
            c_INSTR_WRITE: begin
              w_is_read = 1'b0;
              w_state   = ST_ADDR;
            end
            default: w_state = ST_IGNORE;
          endcase
        end
        ST_ADDR: begin
          // Shifting into an ADDR_W-wide register drops the unused upper bits.
          w_addr = {r_addr[ADDR_W-5:0], i_sqi_sio};
          w_cnt  = r_cnt + 3'd1;
          if (r_cnt == c_ADDR_LAST) begin
            w_cnt   = 3'd0;
            w_half  = 1'b0;
            w_state = r_is_read ? ST_DUMMY : ST_WRITE;
          end
        end
        ST_DUMMY: begin
          w_cnt = r_cnt + 3'd1;
          if (r_cnt == c_DUMMY_LAST) begin
            // Present the first high nibble on the last dummy edge.
            w_state  = ST_READ;
            w_sio    = w_rd_byte[7:4];
            w_sio_en = 1'b1;
            w_half   = 1'b1;
          end
        end
        ST_READ: begin
          w_sio_en = 1'b1;
          if (r_half) begin
            w_sio  = w_rd_byte[3:0];
            w_addr = r_addr + c_ADDR_ONE;
            w_half = 1'b0;
          end else begin
            w_sio  = w_rd_byte[7:4];
            w_half = 1'b1;
          end
        end
        ST_WRITE: begin
          if (r_half) begin
            w_mem_we = 1'b1;
            w_addr   = r_addr + c_ADDR_ONE;
            w_half   = 1'b0;
          end else begin
            w_wdata_hi = i_sqi_sio;
            w_half     = 1'b1;
          end
        end
        ST_IGNORE: begin
          w_state = ST_IGNORE;
        end
        default: w_state = ST_IGNORE;
      endcase
    end
  end

  // State and datapath registers; reset parks in IGNORE until CS is seen high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IGNORE;
      r_cnt      <= 3'd0;
      r_instr_hi <= 4'd0;
      r_is_read  <= 1'b0;
      r_addr     <= '0;
      r_half     <= 1'b0;
      r_wdata_hi <= 4'd0;
      r_sio      <= 4'd0;
      r_sio_en   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_instr_hi <= w_instr_hi;
      r_is_read  <= w_is_read;
      r_addr     <= w_addr;
      r_half     <= w_half;
      r_wdata_hi <= w_wdata_hi;
      r_sio      <= w_sio;
      r_sio_en   <= w_sio_en;
    end
  end

  // Array write on the edge that samples the low nibble of a byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_mem_we) begin
      r_mem[r_addr] <= w_mem_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idli_sqi_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_idli_sqi_mem
// Description : Directed self-checking bench for idli_sqi_mem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idli_sqi_mem;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs  = 1'b1;
  logic [3:0] sio = 4'd0;
  wire  [3:0] o_sio;
  wire        o_en;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rd_data [0:7];
  logic       rd_en_ok;

  idli_sqi_mem #(.ADDR_W(17)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sqi_cs     (cs),
    .i_sqi_sio    (sio),
    .o_sqi_sio    (o_sio),
    .o_sqi_sio_en (o_en)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // One bus edge: drive on the falling edge, observe 1 time unit after rising.
  task automatic tick(input logic c, input logic [3:0] d);
    @(negedge clk);
    cs  = c;
    sio = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] ins, input logic [23:0] a);
    tick(1'b0, ins[7:4]);
    tick(1'b0, ins[3:0]);
    for (int i = 0; i < 6; i++) tick(1'b0, a[23-4*i -: 4]);
  endtask

  // Bytes are taken MSB-first from the 32-bit vector.
  task automatic do_write(input logic [23:0] a, input int n, input logic [31:0] bytes);
    logic [7:0] b;
    send_cmd(8'h02, a);
    for (int k = 0; k < n; k++) begin
      b = bytes[31-8*k -: 8];
      tick(1'b0, b[7:4]);
      tick(1'b0, b[3:0]);
    end
    tick(1'b1, 4'd0);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    send_cmd(8'h03, a);
    tick(1'b0, 4'hF);                    // n=8 dummy
    rd_en_ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick(1'b0, 4'hF);
      if (o_en !== 1'b1) rd_en_ok = 1'b0;
      rd_data[k][7:4] = o_sio;
      tick(1'b0, 4'hF);
      if (o_en !== 1'b1) rd_en_ok = 1'b0;
      rd_data[k][3:0] = o_sio;
    end
    tick(1'b1, 4'd0);
  endtask

  task automatic test_reset;
    logic en_seen;
    rst = 1'b1;
    tick(1'b1, 4'd0);
    tick(1'b1, 4'd0);
    total++;
    if (o_sio !== 4'd0) begin bad++; $display("FAIL reset_sio got=%h exp=0", o_sio); end
    total++;
    if (o_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", o_en); end
    // CS held low straight out of reset: must be ignored entirely.
    rst = 1'b0;
    en_seen = 1'b0;
    send_cmd(8'h03, 24'h000010);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 4'hF);
      if (o_en !== 1'b0) en_seen = 1'b1;
    end
    total++;
    if (en_seen !== 1'b0) begin bad++; $display("FAIL reset_no_drive got=%b exp=0", en_seen); end
    tick(1'b1, 4'd0);
  endtask

  task automatic test_write_read;
    do_write(24'h000010, 2, {8'hA5, 8'h3C, 16'h0});
    send_cmd(8'h03, 24'h000010);
    tick(1'b0, 4'h0);                    // n=8
    total++;
    if (o_en !== 1'b0) begin bad++; $display("FAIL wr_rd_en_n8 got=%b exp=0", o_en); end
    tick(1'b0, 4'h0);                    // n=9
    total++;
    if (o_en !== 1'b1) begin bad++; $display("FAIL wr_rd_en_n9 got=%b exp=1", o_en); end
    total++;
    if (o_sio !== 4'hA) begin bad++; $display("FAIL wr_rd_n9_nib got=%h exp=a", o_sio); end
    tick(1'b1, 4'd0);
    total++;
    if (o_en !== 1'b0) begin bad++; $display("FAIL wr_rd_en_deselect got=%b exp=0", o_en); end
    do_read(24'h000010, 2);
    total++;
    if (rd_data[0] !== 8'hA5) begin bad++; $display("FAIL wr_rd_byte0 got=%h exp=a5", rd_data[0]); end
    total++;
    if (rd_data[1] !== 8'h3C) begin bad++; $display("FAIL wr_rd_byte1 got=%h exp=3c", rd_data[1]); end
    total++;
    if (rd_en_ok !== 1'b1) begin bad++; $display("FAIL wr_rd_en_hold got=%b exp=1", rd_en_ok); end
  endtask

  task automatic test_wrap;
    do_write(24'hFFFFFF, 2, {8'h11, 8'h22, 16'h0});
    do_read(24'h01FFFF, 2);
    total++;
    if (rd_data[0] !== 8'h11) begin bad++; $display("FAIL wrap_top got=%h exp=11", rd_data[0]); end
    total++;
    if (rd_data[1] !== 8'h22) begin bad++; $display("FAIL wrap_rd_cross got=%h exp=22", rd_data[1]); end
    do_read(24'h000000, 1);
    total++;
    if (rd_data[0] !== 8'h22) begin bad++; $display("FAIL wrap_zero got=%h exp=22", rd_data[0]); end
  endtask

  task automatic test_bad_instr;
    logic       en_seen;
    logic [3:0] junk [0:9];
    junk = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
    en_seen = 1'b0;
    tick(1'b0, 4'h0);
    tick(1'b0, 4'h5);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, junk[i]);
      if (o_en !== 1'b0) en_seen = 1'b1;
    end
    total++;
    if (en_seen !== 1'b0) begin bad++; $display("FAIL bad_instr_en got=%b exp=0", en_seen); end
    tick(1'b1, 4'd0);
    do_read(24'h000010, 1);
    total++;
    if (rd_data[0] !== 8'hA5) begin bad++; $display("FAIL bad_instr_mem got=%h exp=a5", rd_data[0]); end
  endtask

  task automatic test_abort;
    do_write(24'h000020, 1, {8'h77, 24'h0});
    send_cmd(8'h02, 24'h000020);
    tick(1'b0, 4'h9);                    // n=8 high nibble only
    tick(1'b1, 4'd0);
    do_read(24'h000020, 1);
    total++;
    if (rd_data[0] !== 8'h77) begin bad++; $display("FAIL abort_half_byte got=%h exp=77", rd_data[0]); end
    // Deselect after the n=5 edge, mid-address.
    tick(1'b0, 4'h0);
    tick(1'b0, 4'h2);
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h0);
    tick(1'b1, 4'd0);
    do_read(24'h000010, 2);
    total++;
    if (rd_data[0] !== 8'hA5 || rd_data[1] !== 8'h3C) begin
      bad++; $display("FAIL abort_addr_next got=%h%h exp=a53c", rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_reset_mid_read;
    logic en_seen;
    send_cmd(8'h03, 24'h000010);
    tick(1'b0, 4'hF);                    // n=8
    tick(1'b0, 4'hF);                    // n=9
    tick(1'b0, 4'hF);                    // n=10
    tick(1'b0, 4'hF);                    // n=11
    total++;
    if (o_sio !== 4'h3) begin bad++; $display("FAIL rst_rd_n11 got=%h exp=3", o_sio); end
    rst = 1'b1;
    tick(1'b0, 4'hF);                    // n=12 with reset
    total++;
    if (o_en !== 1'b0 || o_sio !== 4'd0) begin
      bad++; $display("FAIL rst_rd_outputs got=%b/%h exp=0/0", o_en, o_sio);
    end
    rst = 1'b0;
    en_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 4'h3);
      if (o_en !== 1'b0) en_seen = 1'b1;
    end
    total++;
    if (en_seen !== 1'b0) begin bad++; $display("FAIL rst_rd_no_drive got=%b exp=0", en_seen); end
    tick(1'b1, 4'd0);
    do_read(24'h000010, 2);
    total++;
    if (rd_data[0] !== 8'hA5 || rd_data[1] !== 8'h3C) begin
      bad++; $display("FAIL rst_rd_preserve got=%h%h exp=a53c", rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_back_to_back;
    do_write(24'h000040, 4, 32'h01234567);
    // do_read ends with a single CS-high edge, then the write follows directly.
    do_read(24'h000040, 4);
    do_write(24'h000080, 2, {8'hDE, 8'hAD, 16'h0});
    total++;
    if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== 32'h01234567) begin
      bad++; $display("FAIL b2b_read got=%h%h%h%h exp=01234567",
                      rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
    end
    total++;
    if (rd_en_ok !== 1'b1) begin bad++; $display("FAIL b2b_read_en got=%b exp=1", rd_en_ok); end
    do_read(24'h000080, 2);
    total++;
    if (rd_data[0] !== 8'hDE || rd_data[1] !== 8'hAD) begin
      bad++; $display("FAIL b2b_write got=%h%h exp=dead", rd_data[0], rd_data[1]);
    end
    do_read(24'h000040, 1);
    total++;
    if (rd_data[0] !== 8'h01) begin bad++; $display("FAIL b2b_untouched got=%h exp=01", rd_data[0]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_bad_instr();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
